// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing, one-cycle expiry pulse
// and optional periodic auto-reload from the captured load value.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | counter parked; q holds load/reload value until start
// RUN   | counting down on c_down ticks; periodic mode reloads at expiry
// DONE  | count reached zero (or zero was started); q holds 0 / last value
module countdown_timer #(
    parameter int                 width      = 8,
    parameter logic [width-1:0]   init_value = 8'hff
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             start,
    input  logic             c_down,
    input  logic             clear,
    input  logic             periodic,
    output logic [width-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [width-1:0] ONE  = width'(1);
    localparam logic [width-1:0] ZERO = '0;

    state_t           state;
    logic [width-1:0] reload;

    // Strict priority chain: only the highest active command takes effect,
    // so a start held while running also masks that cycle's tick.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q      <= init_value;
            reload <= init_value;
            state  <= IDLE;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                q     <= reload;
                state <= IDLE;
            end else if (load) begin
                reload <= load_value;
                q      <= load_value;
                state  <= IDLE;
            end else if (start) begin
                case (state)
                    IDLE: begin
                        if (q != ZERO) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (reload != ZERO) begin
                            q     <= reload;
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (c_down && state == RUN) begin
                if (q != ONE) begin
                    q <= q - ONE;
                end else if (periodic && reload != ZERO) begin
                    // q never shows zero in periodic mode
                    q    <= reload;
                    done <= 1'b1;
                end else begin
                    q     <= ZERO;
                    state <= DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    assign expired = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer against a behavioural
// model that tracks count, reload value and running/expired flags.
module tb_countdown_timer;

    localparam logic [7:0] INIT = 8'hff;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       c_down;
    logic       clear;
    logic       periodic;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       expired;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q;
    logic [7:0] m_rl;
    bit         m_run;
    bit         m_exp;
    bit         m_done;

    countdown_timer #(.width(8), .init_value(INIT)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .c_down     (c_down),
        .clear      (clear),
        .periodic   (periodic),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_step();
        m_done = 1'b0;
        if (!rst_b) begin
            m_q = INIT; m_rl = INIT; m_run = 1'b0; m_exp = 1'b0;
        end else if (clear) begin
            m_q = m_rl; m_run = 1'b0; m_exp = 1'b0;
        end else if (load) begin
            m_rl = load_value; m_q = load_value; m_run = 1'b0; m_exp = 1'b0;
        end else if (start) begin
            if (m_exp) begin
                if (m_rl != 0) begin
                    m_q = m_rl; m_run = 1'b1; m_exp = 1'b0;
                end else begin
                    m_done = 1'b1;
                end
            end else if (!m_run) begin
                if (m_q != 0) m_run = 1'b1;
                else begin
                    m_exp = 1'b1; m_done = 1'b1;
                end
            end
        end else if (c_down && m_run) begin
            if (m_q > 1) m_q = m_q - 8'd1;
            else if (periodic && m_rl != 0) begin
                m_q = m_rl; m_done = 1'b1;
            end else begin
                m_q = 8'd0; m_run = 1'b0; m_exp = 1'b1; m_done = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},       32'(q),       32'(m_q));
        chk({tag, ".busy"},    32'(busy),    32'(m_run));
        chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
        chk({tag, ".done"},    32'(done),    32'(m_done));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; c_down = 1'b0; clear = 1'b0;
    endtask

    int pulses;
    int busy_low;

    initial begin
        rst_b = 1'b0; load = 1'b0; load_value = 8'h00; start = 1'b1;
        c_down = 1'b1; clear = 1'b0; periodic = 1'b0;
        m_q = 8'h00; m_rl = 8'h00; m_run = 1'b0; m_exp = 1'b0; m_done = 1'b0;
        #2;

        // Reset with start and c_down also high
        cycle("reset");
        chk("reset.q_const", 32'(q), 32'hff);
        chk("reset.busy_const", 32'(busy), 32'h0);
        rst_b = 1'b1;
        idle_inputs();
        cycle("post_reset");

        // Single shot of 3
        load = 1'b1; load_value = 8'h03;
        cycle("ss_load");
        load = 1'b0; start = 1'b1;
        cycle("ss_start");
        chk("ss_start.q_const", 32'(q), 32'h03);
        start = 1'b0; c_down = 1'b1;
        cycle("ss_t1");
        cycle("ss_t2");
        cycle("ss_t3");
        chk("ss_t3.q_const", 32'(q), 32'h00);
        chk("ss_t3.done_const", 32'(done), 32'h1);
        chk("ss_t3.expired_const", 32'(expired), 32'h1);
        cycle("ss_hold1");
        chk("ss_hold1.done_const", 32'(done), 32'h0);
        cycle("ss_hold2");

        // Periodic reload of 2
        c_down = 1'b0; load = 1'b1; load_value = 8'h02; periodic = 1'b1;
        cycle("per_load");
        load = 1'b0; start = 1'b1;
        cycle("per_start");
        start = 1'b0; c_down = 1'b1;
        pulses = 0; busy_low = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("per_tick");
            if (done) pulses++;
            if (!busy) busy_low++;
        end
        chk("per_pulses", 32'(pulses), 32'd3);
        chk("per_busy_low", 32'(busy_low), 32'd0);
        chk("per_final_q", 32'(q), 32'h02);

        // Pause and restart from DONE
        c_down = 1'b0; periodic = 1'b0; load = 1'b1; load_value = 8'h05;
        cycle("pause_load");
        load = 1'b0; start = 1'b1;
        cycle("pause_start");
        start = 1'b0; c_down = 1'b1;
        cycle("pause_t1");
        cycle("pause_t2");
        c_down = 1'b0;
        for (int i = 0; i < 4; i++) cycle("pause_hold");
        chk("pause_hold.q_const", 32'(q), 32'h03);
        c_down = 1'b1;
        for (int i = 0; i < 3; i++) cycle("pause_resume");
        chk("pause_expired_const", 32'(expired), 32'h1);
        c_down = 1'b0; start = 1'b1;
        cycle("restart");
        chk("restart.q_const", 32'(q), 32'h05);
        chk("restart.busy_const", 32'(busy), 32'h1);

        // Priority: clear beats load/start/c_down
        start = 1'b0; c_down = 1'b1;
        cycle("prio_tick");
        chk("prio_tick.q_const", 32'(q), 32'h04);
        clear = 1'b1; load = 1'b1; load_value = 8'h0a; start = 1'b1;
        cycle("prio_all");
        chk("prio_all.q_const", 32'(q), 32'h05);
        chk("prio_all.busy_const", 32'(busy), 32'h0);
        clear = 1'b0; start = 1'b0; c_down = 1'b0;
        cycle("prio_load");
        chk("prio_load.q_const", 32'(q), 32'h0a);

        // Zero load
        load_value = 8'h00;
        cycle("zero_load");
        load = 1'b0; start = 1'b1;
        cycle("zero_start");
        chk("zero_start.done_const", 32'(done), 32'h1);
        start = 1'b0;
        cycle("zero_gap");
        start = 1'b1;
        cycle("zero_restart");
        chk("zero_restart.expired_const", 32'(expired), 32'h1);
        start = 1'b0;
        cycle("zero_after");

        // Reset mid-count acts only at the edge
        load = 1'b1; load_value = 8'h09;
        cycle("mid_load");
        load = 1'b0; start = 1'b1;
        cycle("mid_start");
        start = 1'b0; c_down = 1'b1;
        cycle("mid_tick");
        rst_b = 1'b0;
        #2;
        chk("sync_reset_q_before_edge", 32'(q), 32'h08);
        cycle("mid_reset");
        chk("mid_reset.q_const", 32'(q), 32'hff);
        rst_b = 1'b1;
        idle_inputs();
        cycle("mid_release");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_b      = ($urandom_range(0, 199) != 0);
            clear      = ($urandom_range(0, 31) == 0);
            load       = ($urandom_range(0, 15) == 0);
            load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            start      = ($urandom_range(0, 7) == 0);
            c_down     = start ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) periodic = ~periodic;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with a run/done state machine. It is the decrementing counterpart to the lab up-counter.
- Counts a programmed value down to zero on enable ticks, then flags expiry with a one-cycle pulse and a sticky level.
- Optional periodic mode auto-reloads on expiry. Used as a timeout/interval generator beside the up-counter in the lab datapath.

Parameters:
- width, 8, counter and load value width in bits
- init_value, 8'hff, value of q and of the reload register after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_b  input  1  synchronous, active-low reset, sampled on rising edge of clk
- load  input  1  capture load_value into reload register and q
- load_value  input  width  value captured by load
- start  input  1  begin counting from current q (IDLE) or from reload register (DONE)
- c_down  input  1  decrement enable (tick); ignored outside RUN
- clear  input  1  abort: q <= reload register, go IDLE
- periodic  input  1  1 = auto-reload on expiry and keep running
- q  output  width  current count (registered)
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse when an expiry occurs
- expired  output  1  high while state is DONE

Behaviour:
- States: IDLE, RUN, DONE. busy = (state==RUN); expired = (state==DONE); both decoded from state register.
- Reset (rst_b=0 at rising edge, any state): q=init_value, reload=init_value, state=IDLE, done=0. No asynchronous effect; outputs change only on edge.
- Per-edge priority: rst_b > clear > load > start > c_down. Only the highest active command acts.
- done defaults to 0 every cycle; set only where stated below.
- clear (any state): q <= reload, state <= IDLE.
- load (any state): reload <= load_value, q <= load_value, state <= IDLE. Counting is never started by load.
- start in IDLE:
  - if q != 0: state <= RUN.
  - if q == 0: state <= DONE, done <= 1.
- start in DONE:
  - if reload != 0: q <= reload, state <= RUN.
  - else: stays DONE, done <= 1.
- start in RUN: ignored.
- RUN with c_down=1:
  - q > 1: q <= q-1.
  - q == 1 and (periodic=0 or reload==0): q <= 0, state <= DONE, done <= 1.
  - q == 1 and periodic=1 and reload != 0: q <= reload, state stays RUN, done <= 1. q never shows 0 in periodic mode.
- RUN with c_down=0: hold (pause).
- periodic is sampled at the expiring edge only; changing it mid-count has no other effect.
- Latency: q changes on the same edge that samples c_down. done is high in the cycle immediately following that edge. A single-shot count of N takes exactly N enabled ticks after start.
- c_down in IDLE or DONE: no effect; q holds (0 in DONE).
- Arithmetic: unsigned, modulo 2^width; no underflow is possible because 0 is never decremented.
- Reset mid-count: aborts immediately; no done pulse.

Test Plan:
- Reset: hold rst_b=0 for 1 edge, with start=1 and c_down=1 also asserted -> q=8'hff, busy=0, expired=0, done=0. Confirm q did not change before the edge (synchronous reset).
- Single-shot: load 8'h03, start, then c_down=1 continuously -> q sequence 03,02,01,00. done=1 for exactly one cycle coincident with q=00. State DONE (expired=1, busy=0). Further c_down holds q=00.
- Periodic: load 8'h02, periodic=1, start, c_down=1 for 6 ticks -> q 02,01,02,01,02,01,02. done pulses on each 01->02 transition (3 pulses). busy stays 1 throughout.
- Pause/restart: load 8'h05, start, tick twice (q=03), c_down=0 for 4 cycles -> q holds 03. Resume to expiry, then start -> q=05, busy=1.
- Priority: in RUN at q=04, assert clear, load (8'h0a), start and c_down on same edge -> q=reload (05), state IDLE. Next edge load alone -> q=0a, state IDLE.
- Zero load: load 8'h00, start -> next cycle expired=1, done=1 for one cycle, q=00. Start again -> stays DONE with another single done pulse.
